cache_axi_bridge: RTL
=====================

// Module: cache_axi_bridge
// PURPOSE
//  Memory-side responder for the core's muxed cache request interface (rd_req/wr_req, type, addr, wstrb).
//  Serves dcache/uncache reads by driving AXI AR/R and returning beats on ret_*.
//  Serves writes (victim write-backs and uncached stores) by driving AXI AW/W/B.
//  Sits between the cache-select mux and the top-level AXI master port.
//  One read and one write may be in flight at once, on independent FSMs.
// PARAMETERS
//  LINE_WORDS  4   words per cache line; line burst arlen/awlen = LINE_WORDS-1
//  DATA_W      32  AXI data width; fixed at 32
// PORTS
//  clk      in   1    core clock
//  rst      in   1    reset, synchronous, active-high
//  rd_req   in   1    read request; accepted when rd_req & rd_rdy
//  rd_type  in   3    000 byte, 001 half, 010 word, 100 cache line
//  rd_addr  in   32   physical read address
//  rd_rdy   out  1    read request accepted this cycle
//  ret_valid/ret_last/ret_data  out  1/1/32  returned read beat; last beat of request
//  wr_req   in   1    write request; accepted when wr_req & wr_rdy
//  wr_type  in   3    same encoding as rd_type
//  wr_addr/wr_wstrb/wr_data  in  32/4/128  address, byte strobe (non-line), line data (word0 = [31:0])
//  wr_rdy   out  1    write request accepted this cycle
//  arvalid/arready  out/in  1/1   AR handshake;  araddr/arlen/arsize  out  32/8/3
//  rvalid/rready/rlast/rdata  in/out/in/in  1/1/1/32  R channel; rresp ignored
//  awvalid/awready  out/in  1/1   AW handshake;  awaddr/awlen/awsize  out  32/8/3
//  wvalid/wready/wlast  out/in/out  1/1/1;  wdata/wstrb  out  32/4
//  bvalid/bready    in/out  1/1   B channel; bresp ignored
// BEHAVIOUR
//  Reset: R_IDLE/W_IDLE, arvalid=awvalid=wvalid=rready=bready=ret_valid=0, beat counter 0.
//  Read FSM R_IDLE->R_AR->R_DATA->R_IDLE:
//   rd_rdy = (R_IDLE) & !hazard (combinational). On accept, latch addr and type; next cycle R_AR.
//   R_AR: arvalid=1, payload held until arready. Line: araddr={addr[31:4],4'b0}, arlen=LINE_WORDS-1, arsize=2.
//   Non-line: araddr=addr, arlen=0, arsize={1'b0,type[1:0]}.
//   R_DATA: rready=1. ret_valid=rvalid, ret_data=rdata, ret_last=rlast, combinational pass-through, zero added latency.
//   rvalid&rlast -> R_IDLE. Earliest next accept is the following cycle.
//  Write FSM W_IDLE->W_AW->W_DATA->W_RESP->W_IDLE:
//   wr_rdy = (W_IDLE). On accept, latch addr, type, wstrb and the 128-bit data.
//   W_AW: awvalid=1 until awready. Address/len/size follow the same rules as AR.
//   W_DATA: wvalid=1; wdata=data[32*cnt+:32]; wstrb=line?4'hF:latched wstrb; wlast=(cnt==awlen).
//   cnt increments on wvalid&wready; wvalid&wready&wlast -> W_RESP, cnt<=0.
//   W_RESP: bready=1 until bvalid -> W_IDLE. W is never issued before the AW handshake completes.
//  Hazard (read-after-write ordering):
//   hazard = (W_IDLE ? wr_req : 1) & (rd_addr[31:4] == pending/incoming wr_addr[31:4]).
//   A read to a line with an outstanding or same-cycle write waits until W_IDLE returns.
//  Simultaneous rd_req & wr_req to different lines: both accepted in the same cycle.
//  Back-to-back: a new request may be accepted the cycle after its FSM returns to idle.
//  Reset mid-burst: both FSMs abandon the transaction and return to idle; the AXI interconnect shares rst.
//  Unsupported types (011, 101-111): treated as word.
// STRUCTURE
//  Type encodings (RT_BYTE, RT_HALF, RT_WORD, RT_LINE) and FSM state codes go in MacroDef.v.
//  Sub-module axi_wr_engine holds the write FSM, data latch and beat counter.
//  The read FSM stays inline.
// TESTING
//  1. Line read, rd_addr=0x1fc0_0124: araddr=0x1fc0_0120, arlen=3, arsize=2.
//     4 R beats (arready delayed 3 cycles) -> 4 ret_valid beats, ret_last only on the 4th.
//  2. Uncached word read, addr 0x1faf_f000: arlen=0, arsize=2; single beat 0xDEADBEEF -> ret_data=0xDEADBEEF, ret_last=1.
//  3. Line write, wr_data=128'h4444_3333_2222_1111...: wdata beats ...1111,...2222,...3333,...4444.
//     wstrb=F, wlast on beat 4; bvalid -> wr_rdy=1 next cycle.
//  4. Byte write, addr 0x...02, wstrb=0100: awsize=0, awlen=0, wstrb=4'b0100, wlast=1.
//  5. Write to line 0x100 pending, then rd_req to 0x108 -> rd_rdy=0 until W_RESP completes.
//     A read to 0x200 in the same window is accepted immediately.
//  6. rst asserted during R_DATA beat 2 -> next cycle all valids 0, rd_rdy=wr_rdy=1.

Source files
------------

// File: rtl/cache_axi_bridge_pkg.sv
// cache_axi_bridge_pkg: request-type codes, FSM states and AXI payload helpers
package cache_axi_bridge_pkg;
  localparam logic [2:0] RT_BYTE = 3'b000;
  localparam logic [2:0] RT_HALF = 3'b001;
  localparam logic [2:0] RT_LINE = 3'b100;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;
  function automatic logic [31:0] axi_addr(input logic [31:0] a, input logic [2:0] t);
    return t == RT_LINE ? {a[31:4], 4'b0} : a;
  endfunction
  function automatic logic [7:0] axi_len(input logic [2:0] t, input int words);
    return t == RT_LINE ? 8'(words - 1) : 8'd0;
  endfunction
  function automatic logic [2:0] axi_size(input logic [2:0] t);
    return t == RT_BYTE ? 3'd0 : t == RT_HALF ? 3'd1 : 3'd2;
  endfunction
endpackage

// File: rtl/cache_axi_bridge_axi_wr_engine.sv
// axi_wr_engine: write FSM issuing AW, beat-counted W bursts and waiting on B
module axi_wr_engine
  import cache_axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req,
  input  logic [2:0]                   wr_type,
  input  logic [31:0]                  wr_addr,
  input  logic [3:0]                   wr_wstrb,
  input  logic [LINE_WORDS*DATA_W-1:0] wr_data,
  output logic                         wr_rdy,
  output logic [27:0]                  pend_line,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [31:0]                  awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic                         wvalid,
  input  logic                         wready,
  output logic                         wlast,
  output logic [DATA_W-1:0]            wdata,
  output logic [3:0]                   wstrb,
  input  logic                         bvalid,
  output logic                         bready
);
  localparam int CW = $clog2(LINE_WORDS);
  w_state_t state, nxt;
  logic [31:0] addr_q;
  logic [2:0] type_q;
  logic [3:0] strb_q;
  logic [LINE_WORDS*DATA_W-1:0] data_q;
  logic [7:0] cnt;
  assign wr_rdy = state == W_IDLE;
  assign pend_line = addr_q[31:4];
  assign awvalid = state == W_AW;
  assign awaddr = axi_addr(addr_q, type_q);
  assign awlen = axi_len(type_q, LINE_WORDS);
  assign awsize = axi_size(type_q);
  assign wvalid = state == W_DATA;
  assign wdata = data_q[DATA_W*int'(cnt[CW-1:0]) +: DATA_W];
  assign wstrb = type_q == RT_LINE ? 4'hF : strb_q;
  assign wlast = cnt == awlen;
  assign bready = state == W_RESP;
  // next state: AW handshake strictly precedes any W beat
  always_comb begin
    nxt = state;
    if (state == W_IDLE && wr_req) nxt = W_AW;
    if (state == W_AW && awready) nxt = W_DATA;
    if (state == W_DATA && wready && wlast) nxt = W_RESP;
    if (state == W_RESP && bvalid) nxt = W_IDLE;
  end
  // state register and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= W_IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (wvalid && wready) cnt <= wlast ? '0 : cnt + 8'd1;
    end
  end
  // request capture on accept
  always_ff @(posedge clk) begin
    if (wr_req && wr_rdy) begin
      addr_q <= wr_addr;
      type_q <= wr_type;
      strb_q <= wr_wstrb;
      data_q <= wr_data;
    end
  end
endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: cache request interface to AXI master with independent read and write FSMs
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_req,
  input  logic [2:0]                   rd_type,
  input  logic [31:0]                  rd_addr,
  output logic                         rd_rdy,
  output logic                         ret_valid,
  output logic                         ret_last,
  output logic [DATA_W-1:0]            ret_data,
  input  logic                         wr_req,
  input  logic [2:0]                   wr_type,
  input  logic [31:0]                  wr_addr,
  input  logic [3:0]                   wr_wstrb,
  input  logic [LINE_WORDS*DATA_W-1:0] wr_data,
  output logic                         wr_rdy,
  output logic                         arvalid,
  input  logic                         arready,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  input  logic                         rvalid,
  output logic                         rready,
  input  logic                         rlast,
  input  logic [DATA_W-1:0]            rdata,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [31:0]                  awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic                         wvalid,
  input  logic                         wready,
  output logic                         wlast,
  output logic [DATA_W-1:0]            wdata,
  output logic [3:0]                   wstrb,
  input  logic                         bvalid,
  output logic                         bready
);
  r_state_t r_state, r_nxt;
  logic [31:0] ra_q;
  logic [2:0] rt_q;
  logic [27:0] pend_line;
  logic hazard;
  axi_wr_engine #(.LINE_WORDS(LINE_WORDS), .DATA_W(DATA_W)) u_wr (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy), .pend_line(pend_line),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready)
  );
  assign hazard = (wr_rdy ? wr_req : 1'b1) && rd_addr[31:4] == (wr_rdy ? wr_addr[31:4] : pend_line);
  assign rd_rdy = r_state == R_IDLE && !hazard;
  assign arvalid = r_state == R_AR;
  assign araddr = axi_addr(ra_q, rt_q);
  assign arlen = axi_len(rt_q, LINE_WORDS);
  assign arsize = axi_size(rt_q);
  assign rready = r_state == R_DATA;
  assign ret_valid = rready && rvalid;
  assign ret_last = rready && rlast;
  assign ret_data = rdata;
  // read next state
  always_comb begin
    r_nxt = r_state;
    if (r_state == R_IDLE && rd_req && rd_rdy) r_nxt = R_AR;
    if (r_state == R_AR && arready) r_nxt = R_DATA;
    if (r_state == R_DATA && rvalid && rlast) r_nxt = R_IDLE;
  end
  // read state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else r_state <= r_nxt;
  end
  // read request capture on accept
  always_ff @(posedge clk) begin
    if (rd_req && rd_rdy) begin
      ra_q <= rd_addr;
      rt_q <= rd_type;
    end
  end
endmodule
